// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode constants, a clog2 helper
// and the threshold legality check also used by the async FIFOs.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Thresholds are legal when almost_full can fire before or at full and
  // almost_empty sits strictly below depth.
  function automatic bit fifo_thresh_ok(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram_1w1r.sv
// One-write one-read storage array; the read port is either a registered
// (reset, enabled) output or a combinational look-up of the read address.
module fifo_ram_1w1r #(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter bit reg_read   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  localparam int depth = 1 << addr_width;

  logic [data_width-1:0] mem [depth];

  // Storage is deliberately not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  if (reg_read) begin : g_reg_read
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata <= '0;
      end else if (rd_en) begin
        rdata <= mem[raddr];
      end
    end
  end else begin : g_comb_read
    logic unused_ctrl;
    assign unused_ctrl = rst ^ rd_en;
    assign rdata       = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with optional first-word-fall-through,
// occupancy count, almost flags and registered overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int data_width    = 8,
  parameter int addr_width    = 4,
  parameter int fwft          = FIFO_MODE_STD,
  parameter int afull_thresh  = 14,
  parameter int aempty_thresh = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wdata,
  input  logic                  rd_en,
  output logic [data_width-1:0] rdata,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int depth = 1 << addr_width;
  localparam logic [addr_width:0] depth_c  = (addr_width+1)'(depth);
  localparam logic [addr_width:0] afull_c  = (addr_width+1)'(afull_thresh);
  localparam logic [addr_width:0] aempty_c = (addr_width+1)'(aempty_thresh);
  localparam logic [addr_width:0] one_c    = (addr_width+1)'(1);

  if (addr_width < 1) begin : g_bad_addr_width
    $fatal(1, "sync_fifo_param: addr_width must be >= 1");
  end
  if (!fifo_thresh_ok(depth, afull_thresh, aempty_thresh)) begin : g_bad_thresh
    $fatal(1, "sync_fifo_param: almost-full/almost-empty threshold out of range");
  end

  logic [addr_width:0] wr_ptr;
  logic [addr_width:0] rd_ptr;
  logic [addr_width:0] count_q;
  logic                rd_acc;
  logic                wr_acc;
  logic                overflow_q;
  logic                underflow_q;

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == depth_c);
  assign almost_full  = (count_q >= afull_c);
  assign almost_empty = (count_q <= aempty_c);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is allowed only when a pop frees a slot in the
  // same cycle; an empty FIFO never bypasses write data to the read side.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + one_c;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + one_c;
      end
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + one_c;
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - one_c;
      end
      overflow_q  <= wr_en && !wr_acc;
      underflow_q <= rd_en && !rd_acc;
    end
  end

  fifo_ram_1w1r #(
    .data_width (data_width),
    .addr_width (addr_width),
    .reg_read   (fwft == FIFO_MODE_STD)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_acc),
    .waddr (wr_ptr[addr_width-1:0]),
    .wdata (wdata),
    .rd_en (rd_acc),
    .raddr (rd_ptr[addr_width-1:0]),
    .rdata (rdata)
  );

  // Standard mode flags each popped word for exactly one cycle; FWFT mode
  // presents the head word whenever anything is stored.
  if (fwft == FIFO_MODE_STD) begin : g_std_valid
    logic valid_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
      end
    end
    assign valid = valid_q;
  end else begin : g_fwft_valid
    assign valid = !empty;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: one standard-mode and one FWFT instance share stimulus
// and are compared every cycle against a queue-based model of the FIFO.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 14;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          rd_en = 1'b0;

  logic [DW-1:0] s_rdata, f_rdata;
  logic          s_valid, f_valid, s_full, f_full, s_empty, f_empty;
  logic          s_afull, f_afull, s_aempty, f_aempty;
  logic [AW:0]   s_count, f_count;
  logic          s_over, f_over, s_under, f_under;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_rdata_std = '0;
  bit            m_valid_std = 1'b0;
  bit            m_over = 1'b0;
  bit            m_under = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .data_width(DW), .addr_width(AW), .fwft(0),
    .afull_thresh(AFULL), .aempty_thresh(AEMPTY)
  ) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(s_rdata), .valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
    .overflow(s_over), .underflow(s_under)
  );

  sync_fifo_param #(
    .data_width(DW), .addr_width(AW), .fwft(1),
    .afull_thresh(AFULL), .aempty_thresh(AEMPTY)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(f_rdata), .valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_over), .underflow(f_under)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: occupancy is the queue length, data order is queue order.
  always @(posedge clk) begin
    bit racc, wacc, was_empty, was_full;
    if (rst) begin
      m_q.delete();
      m_rdata_std = '0;
      m_valid_std = 1'b0;
      m_over      = 1'b0;
      m_under     = 1'b0;
    end else begin
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == DEPTH);
      racc = rd_en && !was_empty;
      wacc = wr_en && (!was_full || racc);
      if (racc) m_rdata_std = m_q.pop_front();
      if (wacc) m_q.push_back(wdata);
      m_valid_std = racc;
      m_over      = wr_en && !wacc;
      m_under     = rd_en && !racc;
    end
  end

  always @(negedge clk) begin
    int n;
    if (checking) begin
      n = m_q.size();
      check_output("std_count", int'(s_count), n);
      check_output("fwft_count", int'(f_count), n);
      check_output("std_empty", int'(s_empty), int'(n == 0));
      check_output("fwft_empty", int'(f_empty), int'(n == 0));
      check_output("std_full", int'(s_full), int'(n == DEPTH));
      check_output("fwft_full", int'(f_full), int'(n == DEPTH));
      check_output("std_afull", int'(s_afull), int'(n >= AFULL));
      check_output("fwft_afull", int'(f_afull), int'(n >= AFULL));
      check_output("std_aempty", int'(s_aempty), int'(n <= AEMPTY));
      check_output("fwft_aempty", int'(f_aempty), int'(n <= AEMPTY));
      check_output("std_overflow", int'(s_over), int'(m_over));
      check_output("fwft_overflow", int'(f_over), int'(m_over));
      check_output("std_underflow", int'(s_under), int'(m_under));
      check_output("fwft_underflow", int'(f_under), int'(m_under));
      check_output("std_valid", int'(s_valid), int'(m_valid_std));
      check_output("std_rdata", int'(s_rdata), int'(m_rdata_std));
      check_output("fwft_valid", int'(f_valid), int'(n != 0));
      if (n != 0) check_output("fwft_rdata", int'(f_rdata), int'(m_q[0]));
    end
  end

  task automatic apply_stimulus(input bit w, input logic [DW-1:0] d, input bit r);
    wr_en = w;
    wdata = d;
    rd_en = r;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(0, 8'h00, 0);
    rst = 1'b0;
    checking = 1'b1;
    check_output("reset_count", int'(s_count), 0);
    check_output("reset_empty", int'(s_empty), 1);
    check_output("reset_aempty", int'(s_aempty), 1);
    check_output("reset_full", int'(s_full), 0);
    check_output("reset_valid", int'(s_valid), 0);

    // 1: fill to full, then one rejected write
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(1, 8'(i), 0);
      if (i == 13) check_output("afull_at_13", int'(s_afull), 0);
      if (i == 14) check_output("afull_at_14", int'(s_afull), 1);
    end
    check_output("fill_count", int'(s_count), 16);
    check_output("fill_full", int'(s_full), 1);
    apply_stimulus(1, 8'h11, 0);
    check_output("overflow_pulse", int'(s_over), 1);
    check_output("overflow_count", int'(s_count), 16);

    // 2: drain in order, then one rejected read
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(0, 8'h00, 1);
      check_output("drain_valid", int'(s_valid), 1);
      check_output("drain_rdata", int'(s_rdata), i);
    end
    check_output("drain_empty", int'(s_empty), 1);
    apply_stimulus(0, 8'h00, 1);
    check_output("underflow_pulse", int'(s_under), 1);
    check_output("underflow_valid", int'(s_valid), 0);

    // 3: simultaneous read/write on full
    for (int i = 0; i < 16; i++) apply_stimulus(1, 8'(8'h21 + i), 0);
    apply_stimulus(1, 8'hAA, 1);
    check_output("full_rw_count", int'(s_count), 16);
    check_output("full_rw_overflow", int'(s_over), 0);
    check_output("full_rw_rdata", int'(s_rdata), 8'h21);
    for (int i = 0; i < 16; i++) apply_stimulus(0, 8'h00, 1);
    check_output("aa_sixteenth", int'(s_rdata), 8'hAA);

    // 4: simultaneous read/write on empty
    apply_stimulus(1, 8'h55, 1);
    check_output("empty_rw_underflow", int'(s_under), 1);
    check_output("empty_rw_count", int'(s_count), 1);
    check_output("empty_rw_fwft_valid", int'(f_valid), 1);
    check_output("empty_rw_fwft_rdata", int'(f_rdata), 8'h55);
    check_output("empty_rw_std_valid", int'(s_valid), 0);
    apply_stimulus(0, 8'h00, 1);
    check_output("pop_55", int'(s_rdata), 8'h55);

    // 5: interleaved traffic across pointer wrap, then three writes
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1, 8'(8'h60 + i), 0);
      apply_stimulus(0, 8'h00, 1);
      check_output("wrap_rdata", int'(s_rdata), 8'h60 + i);
    end
    for (int i = 0; i < 3; i++) apply_stimulus(1, 8'(8'hB0 + i), 0);
    check_output("wrap_count", int'(s_count), 3);
    check_output("wrap_aempty", int'(s_aempty), 0);
    check_output("wrap_fwft_head", int'(f_rdata), 8'hB0);

    // 6: reset with nine words stored and a write pending
    for (int i = 0; i < 6; i++) apply_stimulus(1, 8'(8'hC0 + i), 0);
    check_output("pre_reset_count", int'(s_count), 9);
    rst = 1'b1;
    apply_stimulus(1, 8'h99, 0);
    rst = 1'b0;
    check_output("rst_count", int'(s_count), 0);
    check_output("rst_empty", int'(s_empty), 1);
    check_output("rst_valid", int'(s_valid), 0);
    check_output("rst_fwft_valid", int'(f_valid), 0);
    check_output("rst_overflow", int'(s_over), 0);
    apply_stimulus(0, 8'h00, 0);
    check_output("rst_discard_count", int'(s_count), 0);
    apply_stimulus(1, 8'h77, 0);
    check_output("post_rst_fwft_rdata", int'(f_rdata), 8'h77);
    apply_stimulus(0, 8'h00, 1);
    check_output("post_rst_std_rdata", int'(s_rdata), 8'h77);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, fully parametrised FIFO.
- Next generation of the team's FIFO family, for intra-domain buffering where no CDC is needed.
- Adds over the previous generation: power-of-two depth by parameter, first-word-fall-through (FWFT) mode, fill-level count, programmable almost-full/almost-empty, and write-accept-on-full when a read pops in the same cycle.
- Sits between producer/consumer pipeline stages in the same clock domain.

Parameters:
- data_width, 8, width of wdata/rdata.
- addr_width, 4, pointer index width; depth = 2**addr_width (16).
- fwft, 0, 0 = standard registered-read mode; 1 = first-word-fall-through.
- afull_thresh, 14, almost_full asserts when count >= afull_thresh; legal range 1..depth.
- aempty_thresh, 2, almost_empty asserts when count <= aempty_thresh; legal range 0..depth-1.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wdata  input  data_width  write data.
- rd_en  input  1  read request (pop).
- rdata  output  data_width  read data.
- valid  output  1  rdata holds a valid word.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- almost_full  output  1  count >= afull_thresh.
- almost_empty  output  1  count <= aempty_thresh.
- count  output  addr_width+1  current occupancy, 0..depth.
- overflow  output  1  registered pulse: write rejected last cycle.
- underflow  output  1  registered pulse: read rejected last cycle.

Behaviour:
- Reset:
  - Synchronous and active-high; wins over all requests in the same cycle.
  - Clears wr_ptr, rd_ptr, count, rdata, valid, overflow, underflow to 0.
  - After reset: empty=1, almost_empty=1 (since aempty_thresh >= 0), full=0, almost_full=0.
  - Memory contents are not reset. Reset mid-operation discards all stored words.
- Pointers: wr_ptr and rd_ptr are addr_width+1 bits. The low addr_width bits index the memory; the MSB is the wrap bit. Both increment by 1 modulo 2**(addr_width+1).
- Accept rules, evaluated combinationally each cycle:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_acc). On full, a write is accepted only if a read pops in the same cycle.
  - On empty, a simultaneous rd_en and wr_en accepts the write and rejects the read; no bypass.
- count update: +1 if wr_acc && !rd_acc; -1 if rd_acc && !wr_acc; otherwise unchanged.
- Flags are decoded combinationally from the registered count: full, empty, almost_full, almost_empty.
- Write: when wr_acc, mem[wr_ptr] <= wdata and wr_ptr increments, at the same edge.
- Read, fwft=0:
  - When rd_acc, rdata <= mem[rd_ptr] and rd_ptr increments.
  - valid <= rd_acc, giving a 1-cycle read latency with a one-cycle valid pulse.
  - rdata holds its value when no read is accepted.
- Read, fwft=1:
  - rdata = mem[rd_ptr] combinationally; valid = !empty.
  - rd_en acts as a pop/acknowledge; rd_acc advances rd_ptr.
  - First write into an empty FIFO shows on rdata with valid=1 the cycle after the write edge.
- overflow <= wr_en && !wr_acc.
- underflow <= rd_en && !rd_acc.
- Both error pulses are non-sticky and do not change FIFO state.
- Elaboration checks:
  - afull_thresh must lie in 1..depth.
  - aempty_thresh must lie in 0..depth-1.
  - addr_width must be >= 1.
  - Any violation is a fatal error.

Decomposition:
- Shared package fifo_pkg holds:
  - Mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1.
  - A clog2 helper function.
  - The shared fifo threshold-check macro/function, reused by the async FIFO family.
- One natural sub-module, fifo_ram_1w1r:
  - Parametrised data_width/addr_width array.
  - Synchronous write.
  - Read port selectable between registered and combinational via a parameter.

Test Plan (data_width=8, addr_width=4, afull_thresh=14, aempty_thresh=2):
1. Reset then write 0x01..0x10 (16 writes), fwft=0 -> count reaches 16, full=1; almost_full=1 from count=14; a 17th wr_en -> overflow=1 one cycle later and count stays 16.
2. From full, read 16 times -> rdata 0x01..0x10 in order, each one cycle after rd_en with a valid pulse; empty=1 after the last read; an extra rd_en -> underflow=1 and valid=0.
3. Full FIFO, wr_en=rd_en=1 with wdata=0xAA -> both accepted, count stays 16, no overflow; 0xAA is read out as the 16th subsequent word.
4. Empty FIFO, wr_en=rd_en=1 with wdata=0x55 -> write accepted, read rejected, underflow=1, count=1; fwft=1 build shows rdata=0x55 with valid=1 on the next cycle.
5. Write 20 and read 20 interleaved to force pointer wrap, then write 3 -> count=3, almost_empty=0, data order preserved across the wrap.
6. Assert rst with count=9 while wr_en=1 -> next cycle count=0, empty=1, valid=0, overflow=0, and the write is discarded.
